// File: rtl/disp_pkg.sv
// Shared definitions for the 7-segment scan controller.
// Holds the segment-off pattern, the hex glyph table, the digit limit
// and the scan state encoding.
package disp_pkg;

   // All segments dark (active-low).
   localparam logic [6:0] SEG_OFF = 7'h7F;

   // Largest supported digit count; sizes the digit index.
   localparam int unsigned DIGITS_MAX = 8;

   // Active-low glyphs, bit0 = segment a .. bit6 = segment g.
   // Packed with entry 15 at the MSB end, so HEX_SEG_TBL[n] is the glyph for n.
   localparam logic [15:0][6:0] HEX_SEG_TBL = {
      7'h0E,   // F
      7'h06,   // E
      7'h21,   // d
      7'h46,   // C
      7'h03,   // b
      7'h08,   // A
      7'h10,   // 9
      7'h00,   // 8
      7'h78,   // 7
      7'h02,   // 6
      7'h12,   // 5
      7'h19,   // 4
      7'h30,   // 3
      7'h24,   // 2
      7'h79,   // 1
      7'h40    // 0
   };

   // Scan state: gap with all anodes off, or one digit lit.
   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } state_e;

endpackage : disp_pkg

// File: rtl/hex_to_seg.sv
// Hex nibble to active-low 7-segment glyph (purely combinational).
// Ports:
//   nibble  in  4  hex value 0..F
//   seg_c   out 7  segments a..g (bit0 = a), active-low
module hex_to_seg
   import disp_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg_c
);

   assign seg_c = HEX_SEG_TBL[nibble];

endmodule : hex_to_seg

// File: rtl/disp_scan_ctrl.sv
// Multiplexed scan controller for an up-to-8-digit 7-segment display.
// Steps through digits on DISP_CE ticks with an optional all-off gap before
// each digit, and double-buffers host data so writes land only at a frame
// boundary.
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   DISP_CE             one-CLK scan tick
//   WR                  one-CLK write strobe for DATA_IN / DP_IN
//   DATA_IN, DP_IN      hex nibbles (nibble i -> digit i), decimal points
//   EN_MASK             per-digit enable, used live
//   AN, SEG, SEG_DP     active-low anodes, segments a..g, decimal point
//   FRAME_SYNC          one-CLK pulse at each frame end
//   UPD_DONE            one-CLK pulse when new data reaches the shadow
//   PEND                a write is waiting for the frame boundary
module disp_scan_ctrl
   import disp_pkg::*;
#(
   parameter int unsigned N_DIGITS    = 8,
   parameter int unsigned BLANK_TICKS = 1,
   parameter int unsigned SHOW_TICKS  = 7
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    DISP_CE,
   input  logic                    WR,
   input  logic [4*N_DIGITS-1:0]   DATA_IN,
   input  logic [N_DIGITS-1:0]     DP_IN,
   input  logic [N_DIGITS-1:0]     EN_MASK,
   output logic [N_DIGITS-1:0]     AN,
   output logic [6:0]              SEG,
   output logic                    SEG_DP,
   output logic                    FRAME_SYNC,
   output logic                    UPD_DONE,
   output logic                    PEND
);

   localparam int unsigned DATA_W   = 4 * N_DIGITS;
   localparam int unsigned IDX_W    = $clog2(DIGITS_MAX);
   localparam int unsigned TICK_MAX = (BLANK_TICKS > SHOW_TICKS) ? BLANK_TICKS : SHOW_TICKS;
   localparam int unsigned CNT_W    = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;

   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_TICKS - 1);
   localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SHOW_TICKS - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

   // With no blanking the gap state is skipped entirely.
   localparam state_e ST_FIRST = (BLANK_TICKS == 0) ? ST_SHOW : ST_BLANK;

   // Scan state and data registers
   state_e              state_q,   state_d;
   logic [CNT_W-1:0]    cnt_q,     cnt_d;
   logic [IDX_W-1:0]    idx_q,     idx_d;
   logic [DATA_W-1:0]   shadow_q,  shadow_d;
   logic [N_DIGITS-1:0] sdp_q,     sdp_d;
   logic [DATA_W-1:0]   pending_q, pending_d;
   logic [N_DIGITS-1:0] pdp_q,     pdp_d;
   logic                pend_q,    pend_d;

   // Registered outputs
   logic [N_DIGITS-1:0] an_q,      an_d;
   logic [6:0]          seg_q,     seg_d;
   logic                seg_dp_q,  seg_dp_d;
   logic                frame_q,   frame_d;
   logic                upd_q,     upd_d;

   // Digit selected by the next-state index
   logic [3:0]          sel_nib_c;
   logic                sel_dp_c;
   logic                sel_en_c;
   logic                lit_c;
   logic [6:0]          glyph_c;

   // Scan sequencing, write buffering and frame-boundary transfer
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      shadow_d  = shadow_q;
      sdp_d     = sdp_q;
      pending_d = pending_q;
      pdp_d     = pdp_q;
      pend_d    = pend_q;
      frame_d   = 1'b0;
      upd_d     = 1'b0;

      if (DISP_CE) begin
         unique case (state_q)
            ST_BLANK: begin
               if (cnt_q == BLANK_LAST) begin
                  cnt_d   = '0;
                  state_d = ST_SHOW;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            ST_SHOW: begin
               if (cnt_q == SHOW_LAST) begin
                  cnt_d   = '0;
                  state_d = ST_FIRST;
                  if (idx_q == IDX_LAST) begin
                     idx_d   = '0;
                     frame_d = 1'b1;
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: state_d = ST_FIRST;
         endcase
      end

      // A write coinciding with the boundary bypasses the pending buffer.
      if (frame_d) begin
         if (WR) begin
            shadow_d = DATA_IN;
            sdp_d    = DP_IN;
            pend_d   = 1'b0;
            upd_d    = 1'b1;
         end else if (pend_q) begin
            shadow_d = pending_q;
            sdp_d    = pdp_q;
            pend_d   = 1'b0;
            upd_d    = 1'b1;
         end
      end else if (WR) begin
         pending_d = DATA_IN;
         pdp_d     = DP_IN;
         pend_d    = 1'b1;
      end
   end

   // Pick nibble, point and live enable for the digit about to be shown
   always_comb begin
      sel_nib_c = '0;
      sel_dp_c  = 1'b0;
      sel_en_c  = 1'b0;
      for (int i = 0; i < int'(N_DIGITS); i++) begin
         if (idx_d == IDX_W'(i)) begin
            sel_nib_c = shadow_d[4*i +: 4];
            sel_dp_c  = sdp_d[i];
            sel_en_c  = EN_MASK[i];
         end
      end
   end

   hex_to_seg u_hex_to_seg (
      .nibble (sel_nib_c),
      .seg_c  (glyph_c)
   );

   // Drive pins from next state so they move together with the state change.
   // Segments are forced dark whenever no anode is on.
   always_comb begin
      lit_c    = (state_d == ST_SHOW) && sel_en_c;
      an_d     = '1;
      seg_d    = SEG_OFF;
      seg_dp_d = 1'b1;
      if (lit_c) begin
         for (int i = 0; i < int'(N_DIGITS); i++) begin
            if (idx_d == IDX_W'(i)) begin
               an_d[i] = 1'b0;
            end
         end
         seg_d    = glyph_c;
         seg_dp_d = ~sel_dp_c;
      end
   end

   // State and output registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= ST_FIRST;
         cnt_q     <= '0;
         idx_q     <= '0;
         shadow_q  <= '0;
         sdp_q     <= '0;
         pending_q <= '0;
         pdp_q     <= '0;
         pend_q    <= 1'b0;
         an_q      <= '1;
         seg_q     <= SEG_OFF;
         seg_dp_q  <= 1'b1;
         frame_q   <= 1'b0;
         upd_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shadow_q  <= shadow_d;
         sdp_q     <= sdp_d;
         pending_q <= pending_d;
         pdp_q     <= pdp_d;
         pend_q    <= pend_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
         seg_dp_q  <= seg_dp_d;
         frame_q   <= frame_d;
         upd_q     <= upd_d;
      end
   end

   assign AN         = an_q;
   assign SEG        = seg_q;
   assign SEG_DP     = seg_dp_q;
   assign FRAME_SYNC = frame_q;
   assign UPD_DONE   = upd_q;
   assign PEND       = pend_q;

endmodule : disp_scan_ctrl
